lpc_tdata_uart_tx: RTL and testbench
====================================

// Module: lpc_tdata_uart_tx
// PURPOSE
//  Consumer of the LPC peripheral capture stream (TDATA/READY). Buffers each captured
//  LPC I/O cycle record in a FIFO and serialises it as a 5-byte 8N1 UART frame.
//  Sits between the LPC peripheral and the board debug UART pin, in the LPC clock domain.
// PARAMETERS
//  FIFO_DEPTH    16   records buffered; power of 2, >= 2
//  CLKS_PER_BIT  286  clk_i cycles per UART bit (33 MHz / 115200); >= 2
// PORTS
//  clk_i         in   1    LPC clock (LCLK); single clock domain
//  nrst_i        in   1    asynchronous active-low reset
//  tdata_i       in   32   record: [31:16] addr, [15:8] data, [7:1] rsvd (ignored), [0] dir (1=write)
//  ready_i       in   1    one-cycle strobe; tdata_i valid in the same cycle; no backpressure
//  enable_i      in   1    1 = accept records; 0 = ignore ready_i (FIFO still drains)
//  clr_ovf_i     in   1    clears overflow_o (synchronous pulse)
//  uart_tx_o     out  1    serial line, idle high
//  busy_o        out  1    1 while a frame is being shifted or the FIFO is non-empty
//  fifo_level_o  out  $clog2(FIFO_DEPTH)+1  records currently held
//  overflow_o    out  1    sticky: a record was dropped
// BEHAVIOUR
//  Reset (async, immediate): uart_tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0, FSM=IDLE,
//   FIFO pointers cleared. Reset mid-frame aborts the frame; the line goes high at once.
//  Push: ready_i & enable_i & !full at a rising edge writes {addr,data,dir}.
//  Full: push with registered level==FIFO_DEPTH is dropped, even if a pop occurs in the same
//   cycle; overflow_o set; a pending ovf flag is carried into the next record loaded, then cleared.
//  clr_ovf_i and a new drop in the same cycle: set wins.
//  Simultaneous push/pop when not full: both occur; level unchanged.
//  Frame per record, bytes in order: 8'hA5, {6'b0,ovf,dir}, addr[15:8], addr[7:0], data.
//  Byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT
//   cycles. Consecutive bytes and records are back-to-back (no idle gap) while the FIFO is non-empty.
//  FSM: IDLE -> LOAD (FIFO non-empty: pop into 40-bit shift register, byte_idx=0)
//   -> START -> DATA (8 bits) -> STOP -> if byte_idx<4: byte_idx++, START;
//   else if FIFO non-empty: LOAD; else IDLE.
//  LOAD lasts one cycle and the line stays high. From STOP a new record re-enters LOAD,
//   so a 1-cycle high extension of the stop bit between records is permitted and required.
//  Latency: ready_i at edge N into an empty, idle block -> LOAD at N+1 -> start bit driven
//   from edge N+2.
//  Bit counter: modulo CLKS_PER_BIT, wraps to 0 at each bit boundary; sized $clog2(CLKS_PER_BIT).
//  busy_o = (FSM!=IDLE) | (level!=0); registered. enable_i low never aborts a frame in progress.
// STRUCTURE
//  lpc_pkg: TDATA field offsets (ADDR_MSB/LSB, DATA_MSB/LSB, DIR_BIT), SYNC_BYTE=8'hA5,
//   FRAME_BYTES=5, FSM state localparams.
//  Sub-module lpc_sync_fifo (WIDTH=25, DEPTH=FIFO_DEPTH; level, full, empty outputs);
//   the top holds the FSM, baud counter and shift register.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4; a UART model decodes uart_tx_o)
//  1 Reset: hold nrst_i low -> uart_tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0.
//  2 Single write: tdata_i=32'hF0F0_5A01, 1-cycle ready_i -> bytes A5,01,F0,F0,5A;
//    start bit at edge N+2; frame lasts 5*10*4 cycles.
//  3 Read record: tdata_i=32'h0080_A500 -> bytes A5,00,00,80,A5.
//  4 Burst of 6 strobes on consecutive cycles (FIFO 4) -> first record in flight; 4 queued;
//    6th dropped, overflow_o=1; next record loaded has byte1 bit1 set; later records clear it.
//  5 clr_ovf_i pulse together with a drop -> overflow_o stays 1; an isolated pulse -> 0.
//  6 enable_i=0 with ready_i pulses -> level unchanged; queued frames still complete.
//  7 nrst_i asserted mid data bit -> uart_tx_o high the same time step; FIFO empty after release.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared field offsets, frame constants and FSM states for the LPC capture-to-UART path.
package lpc_pkg;

   localparam int ADDR_MSB = 31;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 8;
   localparam int DIR_BIT  = 0;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 5;

   // Buffered record layout: {addr[15:0], data[7:0], dir}
   localparam int REC_W        = 25;
   localparam int REC_ADDR_MSB = 24;
   localparam int REC_ADDR_LSB = 9;
   localparam int REC_DATA_MSB = 8;
   localparam int REC_DATA_LSB = 1;
   localparam int REC_DIR      = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

endpackage

// File: rtl/lpc_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
module lpc_sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign level   = level_reg;
   assign full    = (level_reg == LVL_W'(DEPTH));
   assign empty   = (level_reg == '0);

endmodule

// File: rtl/lpc_tdata_uart_tx.sv
// Buffers LPC capture records and shifts each out as a 5-byte 8N1 UART frame.
module lpc_tdata_uart_tx
   import lpc_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 286
) (
   input  logic                          clk_i,
   input  logic                          nrst_i,
   input  logic [31:0]                   tdata_i,
   input  logic                          ready_i,
   input  logic                          enable_i,
   input  logic                          clr_ovf_i,
   output logic                          uart_tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam int               FRAME_W  = FRAME_BYTES * 8;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       baud_cnt_reg, baud_cnt_next;
   logic [2:0]             bit_idx_reg, bit_idx_next;
   logic [2:0]             byte_idx_reg, byte_idx_next;
   logic [FRAME_W-1:0]     frame_reg, frame_next;
   logic                   ovf_pend_reg, ovf_pend_next;
   logic                   tx_reg, tx_next;
   logic                   busy_reg;
   logic                   overflow_reg;

   logic [REC_W-1:0]       rec_in, rec_out;
   logic [$clog2(FIFO_DEPTH):0] level;
   logic                   full, empty;
   logic                   push, pop, drop, bit_done;
   logic                   unused_rsvd;

   assign unused_rsvd = ^tdata_i[DATA_LSB-1:DIR_BIT+1];

   assign rec_in   = {tdata_i[ADDR_MSB:ADDR_LSB], tdata_i[DATA_MSB:DATA_LSB], tdata_i[DIR_BIT]};
   assign push     = ready_i & enable_i & ~full;
   assign drop     = ready_i & enable_i & full;
   assign pop      = (state_reg == ST_LOAD);
   assign bit_done = (baud_cnt_reg == CNT_LAST);

   lpc_sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .nrst    (nrst_i),
      .wr_en   (push),
      .wr_data (rec_in),
      .rd_en   (pop),
      .rd_data (rec_out),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      frame_next    = frame_reg;
      ovf_pend_next = ovf_pend_reg;
      tx_next       = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (!empty)
               state_next = ST_LOAD;
         end
         ST_LOAD: begin
            // Byte 0 sits in the low octet so DATA can always transmit frame[0].
            frame_next    = {rec_out[REC_DATA_MSB:REC_DATA_LSB],
                             rec_out[REC_ADDR_LSB+7:REC_ADDR_LSB],
                             rec_out[REC_ADDR_MSB:REC_ADDR_LSB+8],
                             6'b0, ovf_pend_reg, rec_out[REC_DIR],
                             SYNC_BYTE};
            ovf_pend_next = 1'b0;
            byte_idx_next = '0;
            baud_cnt_next = '0;
            state_next    = ST_START;
         end
         ST_START: begin
            baud_cnt_next = bit_done ? '0 : baud_cnt_reg + 1'b1;
            if (bit_done) begin
               bit_idx_next = '0;
               state_next   = ST_DATA;
            end
         end
         ST_DATA: begin
            baud_cnt_next = bit_done ? '0 : baud_cnt_reg + 1'b1;
            if (bit_done) begin
               frame_next   = frame_reg >> 1;
               bit_idx_next = bit_idx_reg + 1'b1;
               if (bit_idx_reg == 3'd7)
                  state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            baud_cnt_next = bit_done ? '0 : baud_cnt_reg + 1'b1;
            if (bit_done) begin
               if (byte_idx_reg < 3'(FRAME_BYTES - 1)) begin
                  byte_idx_next = byte_idx_reg + 1'b1;
                  state_next    = ST_START;
               end else if (!empty) begin
                  state_next = ST_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // A drop in the same cycle as a load must still mark the following record.
      if (drop)
         ovf_pend_next = 1'b1;

      case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = frame_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_reg    <= ST_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         frame_reg    <= '0;
         ovf_pend_reg <= 1'b0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         frame_reg    <= frame_next;
         ovf_pend_reg <= ovf_pend_next;
         tx_reg       <= tx_next;
         busy_reg     <= (state_reg != ST_IDLE) | (level != '0);
         if (drop)
            overflow_reg <= 1'b1;
         else if (clr_ovf_i)
            overflow_reg <= 1'b0;
      end
   end

   assign uart_tx_o    = tx_reg;
   assign busy_o       = busy_reg;
   assign fifo_level_o = level;
   assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_lpc_tdata_uart_tx.sv
// Directed bench: a UART decoder checks every byte on uart_tx_o against a byte scoreboard.
module tb_lpc_tdata_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] tdata = '0;
   logic        ready = 1'b0;
   logic        enable = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        uart_tx;
   logic        busy;
   logic [2:0]  level;
   logic        overflow;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [7:0]  sb[$];
   int          starts_q[$];
   bit          dec_en = 1'b1;
   bit          dec_busy = 1'b0;
   logic [7:0]  dec_byte;
   logic        dec_stop;
   int          dec_sc;
   int          n_edge;
   logic [7:0]  exp_byte;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lpc_tdata_uart_tx #(
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk_i        (clk),
      .nrst_i       (nrst),
      .tdata_i      (tdata),
      .ready_i      (ready),
      .enable_i     (enable),
      .clr_ovf_i    (clr_ovf),
      .uart_tx_o    (uart_tx),
      .busy_o       (busy),
      .fifo_level_o (level),
      .overflow_o   (overflow)
   );

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [31:0] d, input logic ovf);
      sb.push_back(8'hA5);
      sb.push_back({6'b0, ovf, d[0]});
      sb.push_back(d[31:24]);
      sb.push_back(d[23:16]);
      sb.push_back(d[15:8]);
   endtask

   task automatic strobe(input logic [31:0] d);
      tdata = d;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || dec_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 40'(n < budget), 40'd1);
   endtask

   function automatic logic [31:0] mk_rec(input int i);
      return {8'h10 + 8'(i), 8'hC0 ^ 8'(i), 8'h30 + 8'(i), 7'h0, 1'(i)};
   endfunction

   // UART model: sample each bit one clock into its CPB-cycle window.
   always begin
      @(negedge clk);
      if (dec_en && nrst && uart_tx === 1'b0) begin
         dec_busy = 1'b1;
         dec_sc   = cyc;
         for (int i = 0; i < 9; i++) begin
            repeat (CPB) @(negedge clk);
            if (i < 8) dec_byte[i] = uart_tx;
            else       dec_stop    = uart_tx;
         end
         starts_q.push_back(dec_sc);
         check("stop_bit", 40'(dec_stop), 40'd1);
         check("byte_expected", 40'(sb.size() != 0), 40'd1);
         if (sb.size() != 0) begin
            exp_byte = sb.pop_front();
            $display("byte %02h at cycle %0d (expected %02h)", dec_byte, dec_sc, exp_byte);
            check("uart_byte", 40'(dec_byte), 40'(exp_byte));
         end
         dec_busy = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1 reset
      repeat (3) @(negedge clk);
      check("rst_tx", 40'(uart_tx), 40'd1);
      check("rst_busy", 40'(busy), 40'd0);
      check("rst_level", 40'(level), 40'd0);
      check("rst_ovf", 40'(overflow), 40'd0);
      nrst   = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);

      // 2 single write record, latency and frame length
      starts_q.delete();
      push_frame(32'hF0F0_5A01, 1'b0);
      tdata = 32'hF0F0_5A01;
      ready = 1'b1;
      @(negedge clk);
      n_edge = cyc;
      ready  = 1'b0;
      check("t2_level", 40'(level), 40'd1);
      @(negedge clk);
      check("t2_busy", 40'(busy), 40'd1);
      check("t2_load_high", 40'(uart_tx), 40'd1);
      wait_drain("t2_drain", 400);
      check("t2_nbytes", 40'(starts_q.size()), 40'd5);
      check("t2_start_lat", 40'(starts_q[0]), 40'(n_edge + 2));
      check("t2_last_start", 40'(starts_q[4]), 40'(n_edge + 2 + 4 * 10 * CPB));
      repeat (6) @(negedge clk);
      check("t2_idle_busy", 40'(busy), 40'd0);
      check("t2_idle_tx", 40'(uart_tx), 40'd1);

      // 3 read record then back-to-back record with reserved bits set
      starts_q.delete();
      push_frame(32'h0080_A500, 1'b0);
      push_frame(32'h1234_56FE, 1'b0);
      strobe(32'h0080_A500);
      strobe(32'h1234_56FE);
      wait_drain("t3_drain", 800);
      check("t3_nbytes", 40'(starts_q.size()), 40'd10);
      check("t3_rec_gap", 40'(starts_q[5] - starts_q[0]), 40'(5 * 10 * CPB + 1));
      repeat (6) @(negedge clk);

      // 4 burst of 6 into a 4-deep FIFO
      push_frame(mk_rec(0), 1'b0);
      push_frame(mk_rec(1), 1'b1);
      push_frame(mk_rec(2), 1'b0);
      push_frame(mk_rec(3), 1'b0);
      push_frame(mk_rec(4), 1'b0);
      for (int i = 0; i < 6; i++) begin
         tdata = mk_rec(i);
         ready = 1'b1;
         @(negedge clk);
      end
      ready = 1'b0;
      check("t4_level_full", 40'(level), 40'(DEPTH));
      check("t4_ovf_set", 40'(overflow), 40'd1);
      wait_drain("t4_drain", 1500);
      check("t4_ovf_sticky", 40'(overflow), 40'd1);
      repeat (6) @(negedge clk);

      // 5 clr_ovf: isolated pulse clears, coincident drop wins
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t5_clr_iso", 40'(overflow), 40'd0);
      push_frame(mk_rec(8), 1'b0);
      push_frame(mk_rec(9), 1'b1);
      push_frame(mk_rec(10), 1'b0);
      push_frame(mk_rec(11), 1'b0);
      push_frame(mk_rec(12), 1'b0);
      for (int i = 0; i < 6; i++) begin
         tdata   = mk_rec(8 + i);
         ready   = 1'b1;
         clr_ovf = (i == 5);
         @(negedge clk);
      end
      ready   = 1'b0;
      clr_ovf = 1'b0;
      check("t5_set_wins", 40'(overflow), 40'd1);
      wait_drain("t5_drain", 1500);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t5_clr_after", 40'(overflow), 40'd0);
      repeat (4) @(negedge clk);

      // 6 enable low ignores strobes but queued frames complete
      push_frame(32'hAAAA_5501, 1'b0);
      push_frame(32'h5555_AA00, 1'b0);
      strobe(32'hAAAA_5501);
      strobe(32'h5555_AA00);
      repeat (10) @(negedge clk);
      check("t6_level_pre", 40'(level), 40'd1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) strobe(32'hDEAD_BE01);
      check("t6_level_hold", 40'(level), 40'd1);
      check("t6_ovf", 40'(overflow), 40'd0);
      wait_drain("t6_drain", 800);
      check("t6_level_end", 40'(level), 40'd0);
      enable = 1'b1;
      repeat (6) @(negedge clk);

      // 7 reset in the middle of a data bit
      dec_en = 1'b0;
      strobe(32'hC3C3_3C01);
      repeat (20) @(negedge clk);
      check("t7_mid_bit", 40'(uart_tx), 40'd0);
      nrst = 1'b0;
      #1;
      check("t7_tx_async", 40'(uart_tx), 40'd1);
      check("t7_level", 40'(level), 40'd0);
      check("t7_busy", 40'(busy), 40'd0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      repeat (60) @(negedge clk);
      check("t7_post_tx", 40'(uart_tx), 40'd1);
      check("t7_post_busy", 40'(busy), 40'd0);
      check("t7_post_level", 40'(level), 40'd0);
      dec_en = 1'b1;

      // recovery frame after reset
      push_frame(32'hABCD_EF01, 1'b0);
      strobe(32'hABCD_EF01);
      wait_drain("t7_recover", 400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
